// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES core.
// The S-boxes are computed (inverse plus affine map), which avoids a 256-entry literal table.
package aes_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_KEXP,
        S_INIT,
        S_ROUND
    } aes_state_e;

    function automatic int nk(input int key_mode);
        return 2 + 2 * key_mode;
    endfunction

    function automatic int nr(input int key_mode);
        return 8 + 2 * key_mode;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // b^254 is the multiplicative inverse; zero maps to zero as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = b;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] v;
        v = gf_inv(b);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return gf_inv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

endpackage

// File: rtl/aes_crypt_core_if.sv
// Request/response bundle of the AES core; KEY_MODE must match the core it connects to.
interface aes_crypt_core_if #(
    parameter int KEY_MODE = 1
);
    localparam int KEYW = 64 * (KEY_MODE + 1);

    logic              start;
    logic              decrypt;
    logic [127:0]      data_in;
    logic [KEYW-1:0]   key;
    logic              busy;
    logic              done;
    logic [127:0]      data_out;

    modport master (output start, decrypt, data_in, key, input busy, done, data_out);
    modport slave  (input start, decrypt, data_in, key, output busy, done, data_out);
endinterface

// File: rtl/aes_round.sv
// One combinational AES round, forward or inverse; final drops (Inv)MixColumns.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rk_i,
    input  logic         decrypt_i,
    input  logic         final_i,
    output logic [127:0] state_o
);

    logic [127:0] enc_sr;
    logic [127:0] enc_mc;
    logic [127:0] dec_sr;
    logic [127:0] dec_ark;
    logic [127:0] dec_mc;

    // Byte n sits at [127-8n -: 8] and is row n%4, column n/4.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        enc_sr  = '0;
        enc_mc  = '0;
        dec_sr  = '0;
        dec_ark = '0;
        dec_mc  = '0;
        state_o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                enc_sr[127-8*(4*c+r) -: 8] = sbox(state_i[127-8*(4*((c+r)%4)+r) -: 8]);
                dec_sr[127-8*(4*c+r) -: 8] = inv_sbox(state_i[127-8*(4*((c+4-r)%4)+r) -: 8]);
            end
        end
        dec_ark = dec_sr ^ rk_i;
        for (int c = 0; c < 4; c++) begin
            enc_mc[127-32*c -: 32] = mix_col(enc_sr[127-32*c -: 32]);
            dec_mc[127-32*c -: 32] = inv_mix_col(dec_ark[127-32*c -: 32]);
        end
        if (decrypt_i) state_o = final_i ? dec_ark : dec_mc;
        else           state_o = (final_i ? enc_sr : enc_mc) ^ rk_i;
    end

endmodule

// File: rtl/aes_crypt_core.sv
// Iterative AES core: latches a request, expands the key one word per clock,
// then runs one round per clock and pulses done with the result.
module aes_crypt_core
    import aes_pkg::*;
#(
    parameter int KEY_MODE = 1
) (
    input  logic             clk,
    input  logic             rst,
    aes_crypt_core_if.slave  bus
);

    localparam int NK     = nk(KEY_MODE);
    localparam int NR     = nr(KEY_MODE);
    localparam int KEYW   = 64 * (KEY_MODE + 1);
    localparam int NWORDS = 4 * (NR + 1);
    localparam int IW     = $clog2(NWORDS);

    if (KEY_MODE < 1 || KEY_MODE > 3) begin : g_bad_key_mode
        $error("aes_crypt_core: KEY_MODE must be 1, 2 or 3");
    end

    aes_state_e     state_q, state_d;
    logic [31:0]    w_q [NWORDS];
    logic [31:0]    w_d [NWORDS];
    logic [IW-1:0]  idx_q, idx_d;
    logic [2:0]     kpos_q, kpos_d;
    logic [3:0]     rci_q, rci_d;
    logic [3:0]     round_q, round_d;
    logic [127:0]   data_q, data_d;
    logic           dec_q, dec_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [127:0]   dout_q, dout_d;

    logic [31:0]    temp;
    logic [31:0]    new_w;
    logic [3:0]     r_sel;
    logic [IW-1:0]  rk_base;
    logic [127:0]   rk;
    logic [127:0]   round_out;
    logic           final_round;

    // kpos tracks i mod Nk and rci tracks i/Nk, avoiding a divider.
    always_comb begin
        temp = w_q[idx_q - IW'(1)];
        if (kpos_q == 3'd0)
            temp = sub_word(rot_word(temp)) ^ {rcon(rci_q), 24'h000000};
        else if (NK == 8 && kpos_q == 3'd4)
            temp = sub_word(temp);
        new_w = w_q[idx_q - IW'(NK)] ^ temp;
    end

    always_comb begin
        if (state_q == S_INIT) r_sel = dec_q ? 4'(NR) : 4'd0;
        else                   r_sel = dec_q ? 4'(NR) - round_q : round_q;
        rk_base = IW'({r_sel, 2'b00});
        rk = {w_q[rk_base], w_q[rk_base + IW'(1)], w_q[rk_base + IW'(2)], w_q[rk_base + IW'(3)]};
    end

    assign final_round = (round_q == 4'(NR));

    aes_round u_round (
        .state_i   (data_q),
        .rk_i      (rk),
        .decrypt_i (dec_q),
        .final_i   (final_round),
        .state_o   (round_out)
    );

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        idx_d   = idx_q;
        kpos_d  = kpos_q;
        rci_d   = rci_q;
        round_d = round_q;
        data_d  = data_q;
        dec_d   = dec_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dout_d  = dout_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    data_d = bus.data_in;
                    dec_d  = bus.decrypt;
                    for (int j = 0; j < NK; j++) w_d[j] = bus.key[KEYW-1-32*j -: 32];
                    idx_d   = IW'(NK);
                    kpos_d  = 3'd0;
                    rci_d   = 4'd1;
                    busy_d  = 1'b1;
                    state_d = S_KEXP;
                end
            end
            S_KEXP: begin
                w_d[idx_q] = new_w;
                idx_d  = idx_q + IW'(1);
                kpos_d = (kpos_q == 3'(NK - 1)) ? 3'd0 : kpos_q + 3'd1;
                if (kpos_q == 3'd0) rci_d = rci_q + 4'd1;
                if (idx_q == IW'(NWORDS - 1)) state_d = S_INIT;
            end
            S_INIT: begin
                data_d  = data_q ^ rk;
                round_d = 4'd1;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                data_d = round_out;
                if (final_round) begin
                    dout_d  = round_out;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            // NOTE: the round-key array is cleared too, so an aborted request leaves no stale key words behind.
            for (int i = 0; i < NWORDS; i++) w_q[i] <= '0;
            idx_q   <= '0;
            kpos_q  <= '0;
            rci_q   <= '0;
            round_q <= '0;
            data_q  <= '0;
            dec_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            // NOTE: non-blocking updates keep every flop sampling pre-edge values regardless of statement order.
            state_q <= state_d;
            w_q     <= w_d;
            idx_q   <= idx_d;
            kpos_q  <= kpos_d;
            rci_q   <= rci_d;
            round_q <= round_d;
            data_q  <= data_d;
            dec_q   <= dec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.data_out = dout_q;

endmodule

// File: tb/tb_aes_crypt_core.sv
// Directed FIPS-197 vectors for all three key sizes plus protocol corner cases.
module tb_aes_crypt_core;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [191:0] KEY192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam int CYC_MAX = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    aes_crypt_core_if #(.KEY_MODE(1)) if128 ();
    aes_crypt_core_if #(.KEY_MODE(2)) if192 ();
    aes_crypt_core_if #(.KEY_MODE(3)) if256 ();

    aes_crypt_core #(.KEY_MODE(1)) u_dut128 (.clk(clk), .rst(rst), .bus(if128));
    aes_crypt_core #(.KEY_MODE(2)) u_dut192 (.clk(clk), .rst(rst), .bus(if192));
    aes_crypt_core #(.KEY_MODE(3)) u_dut256 (.clk(clk), .rst(rst), .bus(if256));

    function automatic logic [127:0] ct_of(input int mode);
        case (mode)
            1:       return CT128;
            2:       return CT192;
            default: return CT256;
        endcase
    endfunction

    function automatic int lat_of(input int mode);
        case (mode)
            1:       return 51;
            2:       return 59;
            default: return 67;
        endcase
    endfunction

    task automatic set_in(input int mode, input logic st, input logic dec, input logic [127:0] d);
        case (mode)
            1: begin if128.start = st; if128.decrypt = dec; if128.data_in = d; if128.key = KEY128; end
            2: begin if192.start = st; if192.decrypt = dec; if192.data_in = d; if192.key = KEY192; end
            default: begin if256.start = st; if256.decrypt = dec; if256.data_in = d; if256.key = KEY256; end
        endcase
    endtask

    function automatic logic get_busy(input int mode);
        case (mode)
            1:       return if128.busy;
            2:       return if192.busy;
            default: return if256.busy;
        endcase
    endfunction

    function automatic logic get_done(input int mode);
        case (mode)
            1:       return if128.done;
            2:       return if192.done;
            default: return if256.done;
        endcase
    endfunction

    function automatic logic [127:0] get_dout(input int mode);
        case (mode)
            1:       return if128.data_out;
            2:       return if192.data_out;
            default: return if256.data_out;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a request now, returns #1 after the done edge (or after CYC_MAX cycles).
    task automatic run_op(input int mode, input logic dec, input logic [127:0] din,
                          output logic [127:0] dout, output int cyc, output logic busy0);
        set_in(mode, 1'b1, dec, din);
        tick();
        set_in(mode, 1'b0, dec, din);
        busy0 = get_busy(mode);
        cyc = 0;
        while (!get_done(mode) && cyc < CYC_MAX) begin
            tick();
            cyc++;
        end
        dout = get_dout(mode);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int m = 1; m <= 3; m++) set_in(m, 1'b0, 1'b0, '0);
        tick();
        tick();
        rst = 1'b0;
        for (int m = 1; m <= 3; m++) begin
            tests_run++;
            if (get_busy(m) !== 1'b0) begin fails++; $display("FAIL reset_busy mode%0d: got %b want 0", m, get_busy(m)); end
            tests_run++;
            if (get_done(m) !== 1'b0) begin fails++; $display("FAIL reset_done mode%0d: got %b want 0", m, get_done(m)); end
            tests_run++;
            if (get_dout(m) !== 128'h0) begin fails++; $display("FAIL reset_dout mode%0d: got %h want 0", m, get_dout(m)); end
        end
    endtask

    task automatic test_encrypt();
        logic [127:0] dout;
        int cyc;
        logic b0;
        for (int m = 1; m <= 3; m++) begin
            run_op(m, 1'b0, PT, dout, cyc, b0);
            tests_run++;
            if (b0 !== 1'b1) begin fails++; $display("FAIL enc_busy mode%0d: got %b want 1", m, b0); end
            tests_run++;
            if (dout !== ct_of(m)) begin fails++; $display("FAIL enc_result mode%0d: got %h want %h", m, dout, ct_of(m)); end
            tests_run++;
            if (cyc !== lat_of(m)) begin fails++; $display("FAIL enc_latency mode%0d: got %0d want %0d", m, cyc, lat_of(m)); end
            tick();
            tests_run++;
            if (get_done(m) !== 1'b0) begin fails++; $display("FAIL done_width mode%0d: got %b want 0", m, get_done(m)); end
        end
    endtask

    task automatic test_decrypt();
        logic [127:0] dout;
        int cyc;
        logic b0;
        for (int m = 1; m <= 3; m++) begin
            run_op(m, 1'b1, ct_of(m), dout, cyc, b0);
            tests_run++;
            if (dout !== PT) begin fails++; $display("FAIL dec_result mode%0d: got %h want %h", m, dout, PT); end
            tests_run++;
            if (cyc !== lat_of(m)) begin fails++; $display("FAIL dec_latency mode%0d: got %0d want %0d", m, cyc, lat_of(m)); end
            tick();
        end
    endtask

    // The decrypt is raised in the done cycle, so its latency proves it was accepted immediately.
    task automatic test_back_to_back();
        logic [127:0] ct;
        logic [127:0] pt;
        int cyc;
        logic b0;
        for (int m = 1; m <= 3; m += 2) begin
            run_op(m, 1'b0, PT, ct, cyc, b0);
            run_op(m, 1'b1, ct, pt, cyc, b0);
            tests_run++;
            if (ct !== ct_of(m)) begin fails++; $display("FAIL b2b_ct mode%0d: got %h want %h", m, ct, ct_of(m)); end
            tests_run++;
            if (pt !== PT) begin fails++; $display("FAIL b2b_pt mode%0d: got %h want %h", m, pt, PT); end
            tests_run++;
            if (cyc !== lat_of(m)) begin fails++; $display("FAIL b2b_latency mode%0d: got %0d want %0d", m, cyc, lat_of(m)); end
            tick();
        end
    endtask

    task automatic test_ignore_start();
        int cyc;
        set_in(1, 1'b1, 1'b0, PT);
        tick();
        set_in(1, 1'b0, 1'b0, PT);
        cyc = 0;
        repeat (10) begin tick(); cyc++; end
        set_in(1, 1'b1, 1'b1, ~PT);
        tick();
        cyc++;
        set_in(1, 1'b0, 1'b0, PT);
        tests_run++;
        if (get_busy(1) !== 1'b1) begin fails++; $display("FAIL ign_busy: got %b want 1", get_busy(1)); end
        while (!get_done(1) && cyc < CYC_MAX) begin tick(); cyc++; end
        tests_run++;
        if (get_dout(1) !== CT128) begin fails++; $display("FAIL ign_result: got %h want %h", get_dout(1), CT128); end
        tests_run++;
        if (cyc !== 51) begin fails++; $display("FAIL ign_latency: got %0d want 51", cyc); end
        repeat (5) tick();
        tests_run++;
        if (get_dout(1) !== CT128 || get_done(1) !== 1'b0) begin
            fails++;
            $display("FAIL hold_idle: got dout=%h done=%b want dout=%h done=0", get_dout(1), get_done(1), CT128);
        end
        set_in(1, 1'b1, 1'b1, CT128);
        tick();
        set_in(1, 1'b0, 1'b1, CT128);
        cyc = 0;
        repeat (30) begin tick(); cyc++; end
        tests_run++;
        if (get_dout(1) !== CT128) begin fails++; $display("FAIL hold_busy: got %h want %h", get_dout(1), CT128); end
        while (!get_done(1) && cyc < CYC_MAX) begin tick(); cyc++; end
        tests_run++;
        if (get_dout(1) !== PT || cyc !== 51) begin
            fails++;
            $display("FAIL ign_dec: got %h at %0d want %h at 51", get_dout(1), cyc, PT);
        end
        tick();
    endtask

    task automatic test_reset_abort(input int at_cycle);
        logic [127:0] dout;
        int cyc;
        logic b0;
        logic seen;
        set_in(1, 1'b1, 1'b0, PT);
        tick();
        set_in(1, 1'b0, 1'b0, PT);
        repeat (at_cycle) tick();
        tests_run++;
        if (get_busy(1) !== 1'b1) begin fails++; $display("FAIL abort%0d_busy_pre: got %b want 1", at_cycle, get_busy(1)); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (get_busy(1) !== 1'b0 || get_done(1) !== 1'b0 || get_dout(1) !== 128'h0) begin
            fails++;
            $display("FAIL abort%0d_state: got busy=%b done=%b dout=%h want 0 0 0", at_cycle, get_busy(1), get_done(1), get_dout(1));
        end
        seen = 1'b0;
        repeat (80) begin
            tick();
            if (get_done(1) === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin fails++; $display("FAIL abort%0d_no_done: got %b want 0", at_cycle, seen); end
        run_op(1, 1'b0, PT, dout, cyc, b0);
        tests_run++;
        if (dout !== CT128 || cyc !== 51) begin
            fails++;
            $display("FAIL abort%0d_next: got %h at %0d want %h at 51", at_cycle, dout, cyc, CT128);
        end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort(20);
        test_reset_abort(45);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
